// File: rtl/gj_pkg.sv
// Shared encodings for the Gauss-Jordan pivot sequencer: FSM states and run status.
// The multiplier pipeline depth lives here so the sequencer can bound its watchdog against it.
package gj_pkg;

  localparam int MUL_PIPE_LAT = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_NORM = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_MUL  = 3'd3,
    S_WAIT_UPD  = 3'd4,
    S_DRAIN     = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_SINGULAR = 2'd1,
    STAT_TIMEOUT  = 2'd2,
    STAT_ABORTED  = 2'd3
  } status_t;

endpackage

// File: rtl/gj_watchdog.sv
// Loadable saturating up-counter; hit_o flags the increment that lands on LIMIT.
// Zero latency on hit_o (combinational from count and inc_i); no backpressure.
module gj_watchdog #(
  parameter int LIMIT = 15,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = (cnt_q == {W{1'b1}}) ? cnt_q : cnt_q + W'(1);
  // Hit on the cycle the count reaches LIMIT so the caller can leave the state on that edge.
  assign hit_o   = inc_i && (cnt_inc == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gj_pivot_sequencer.sv
// Per-pivot loop of the Gauss-Jordan inverter: normalise -> column multiply -> row update, k = 0..MAT_SIZE-1.
// Single-cycle pulse handshakes, one pivot in flight; GJ_SEQ_PERF_EN adds busy/stall counters.
module gj_pivot_sequencer
  import gj_pkg::*;
#(
  parameter int MAT_SIZE    = 8,
  parameter int MUL_TIMEOUT = 15,
  parameter int CNTW        = $clog2(MAT_SIZE) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            norm_vld,
  input  logic            pivot_zero,
  output logic            norm_rdy,
  output logic            mul_input_ready,
  output logic [CNTW-1:0] mul_op_cnt,
  input  logic            mul_out_vld,
  output logic            upd_start,
  output logic [CNTW-1:0] upd_op_cnt,
  input  logic            upd_done,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status
`ifdef GJ_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [2:0] IDLE      = S_IDLE;
  localparam logic [2:0] WAIT_NORM = S_WAIT_NORM;
  localparam logic [2:0] ISSUE     = S_ISSUE;
  localparam logic [2:0] WAIT_MUL  = S_WAIT_MUL;
  localparam logic [2:0] WAIT_UPD  = S_WAIT_UPD;
  localparam logic [2:0] DRAIN     = S_DRAIN;
  localparam logic [2:0] FINISH    = S_FINISH;

  localparam logic [CNTW-1:0] K_LAST = CNTW'(MAT_SIZE - 1);
  // Never let the watchdog fire before the multiplier pipeline could possibly answer.
  localparam int WD_LIMIT = (MUL_TIMEOUT > MUL_PIPE_LAT) ? MUL_TIMEOUT : MUL_PIPE_LAT + 1;

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] k_q, k_d;
  logic [CNTW-1:0] op_cnt_q, op_cnt_d;
  status_t         status_q, status_d;
  logic            upd_start_q, upd_start_d;
  logic            wd_load, wd_inc, wd_hit;

  assign wd_load = (state_q == ISSUE);
  assign wd_inc  = (state_q == WAIT_MUL) || (state_q == DRAIN);

  gj_watchdog #(
    .LIMIT (WD_LIMIT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load_i (wd_load),
    .inc_i  (wd_inc),
    .hit_o  (wd_hit)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    op_cnt_d    = op_cnt_q;
    status_d    = status_q;
    upd_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d      = '0;
          status_d = STAT_OK;
          state_d  = WAIT_NORM;
        end
      end
      WAIT_NORM: begin
        if (abort) begin
          status_d = STAT_ABORTED;
          state_d  = FINISH;
        end else if (norm_vld && pivot_zero) begin
          status_d = STAT_SINGULAR;
          state_d  = FINISH;
        end else if (norm_vld) begin
          op_cnt_d = k_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = abort ? DRAIN : WAIT_MUL;
      end
      WAIT_MUL: begin
        // A result or expiry coinciding with abort already settles the multiplier; skip DRAIN.
        if (abort) begin
          if (mul_out_vld || wd_hit) begin
            status_d = STAT_ABORTED;
            state_d  = FINISH;
          end else begin
            state_d = DRAIN;
          end
        end else if (mul_out_vld) begin
          upd_start_d = 1'b1;
          state_d     = WAIT_UPD;
        end else if (wd_hit) begin
          status_d = STAT_TIMEOUT;
          state_d  = FINISH;
        end
      end
      WAIT_UPD: begin
        if (abort) begin
          status_d = STAT_ABORTED;
          state_d  = FINISH;
        end else if (upd_done) begin
          if (k_q == K_LAST) begin
            status_d = STAT_OK;
            state_d  = FINISH;
          end else begin
            k_d     = k_q + CNTW'(1);
            state_d = WAIT_NORM;
          end
        end
      end
      DRAIN: begin
        if (mul_out_vld || wd_hit) begin
          status_d = STAT_ABORTED;
          state_d  = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      op_cnt_q    <= '0;
      status_q    <= STAT_OK;
      upd_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      op_cnt_q    <= op_cnt_d;
      status_q    <= status_d;
      upd_start_q <= upd_start_d;
    end
  end

  assign norm_rdy        = (state_q == WAIT_NORM);
  assign mul_input_ready = (state_q == ISSUE);
  assign mul_op_cnt      = op_cnt_q;
  assign upd_start       = upd_start_q;
  assign upd_op_cnt      = k_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FINISH);
  assign status          = status_q;

`ifdef GJ_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;
  logic        in_stall;

  assign in_stall = (state_q == WAIT_NORM) || (state_q == WAIT_UPD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        perf_cycles_q <= '0;
        perf_stall_q  <= '0;
      end
    end else begin
      if (perf_cycles_q != 32'hFFFF_FFFF) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (in_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_gj_pivot_sequencer.sv
// Scoreboard bench for gj_pivot_sequencer at MAT_SIZE=4: nominal, singular, timeout, abort, corner events.
// Drives and samples on the falling edge; expectations are queued as stimulus is applied.
module tb_gj_pivot_sequencer;

  localparam int MS      = 4;
  localparam int MT      = 15;
  localparam int CW      = $clog2(MS) + 1;
  localparam int UPD_LAT = 3;

  logic          clk = 1'b0;
  logic          reset, start, abort, norm_vld, pivot_zero, mul_out_vld, upd_done;
  logic          norm_rdy, mul_input_ready, upd_start, busy, done;
  logic [CW-1:0] mul_op_cnt, upd_op_cnt;
  logic [1:0]    status;
`ifdef GJ_SEQ_PERF_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int norm_cnt = 0;
  int stall_upd = 0;
  int exp_op[$];
  int exp_upd[$];
  int exp_status[$];

  always #5 clk = ~clk;

  gj_pivot_sequencer #(
    .MAT_SIZE    (MS),
    .MUL_TIMEOUT (MT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .norm_vld        (norm_vld),
    .pivot_zero      (pivot_zero),
    .norm_rdy        (norm_rdy),
    .mul_input_ready (mul_input_ready),
    .mul_op_cnt      (mul_op_cnt),
    .mul_out_vld     (mul_out_vld),
    .upd_start       (upd_start),
    .upd_op_cnt      (upd_op_cnt),
    .upd_done        (upd_done),
    .busy            (busy),
    .done            (done),
    .status          (status)
`ifdef GJ_SEQ_PERF_EN
    ,
    .perf_cycles     (perf_cycles),
    .perf_stall      (perf_stall)
`endif
  );

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit sel_sig(input int sel);
    case (sel)
      0:       return norm_rdy;
      1:       return mul_input_ready;
      2:       return upd_start;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, input string tag);
    int n = 0;
    while (!sel_sig(sel) && n < budget) begin
      tick();
      n++;
    end
    if (!sel_sig(sel)) chk_eq(tag, 0, 1);
  endtask

  task automatic chk_quiet(input string pfx);
    chk_eq({pfx, "_busy"}, int'(busy), 0);
    chk_eq({pfx, "_done"}, int'(done), 0);
    chk_eq({pfx, "_norm_rdy"}, int'(norm_rdy), 0);
    chk_eq({pfx, "_mul_rdy"}, int'(mul_input_ready), 0);
    chk_eq({pfx, "_upd_start"}, int'(upd_start), 0);
    chk_eq({pfx, "_status"}, int'(status), 0);
    chk_eq({pfx, "_mul_op_cnt"}, int'(mul_op_cnt), 0);
    chk_eq({pfx, "_upd_op_cnt"}, int'(upd_op_cnt), 0);
  endtask

  task automatic start_run();
    busy_cnt  = 0;
    norm_cnt  = 0;
    stall_upd = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One clean pivot; poke adds a spurious mul_out_vld in WAIT_NORM and a start while busy.
  task automatic run_pivot(input int k, input int mlat, input bit last, input bit poke);
    wait_sig(0, 60, "wait_norm");
    mul_out_vld = poke;
    tick();
    mul_out_vld = 1'b0;
    tick();
    norm_vld = 1'b1;
    pivot_zero = 1'b0;
    exp_op.push_back(k);
    tick();
    norm_vld = 1'b0;
    chk_eq("issue_cycle", int'(mul_input_ready), 1);
    for (int c = 1; c <= mlat; c++) begin
      tick();
      start = poke && (c == 2);
    end
    mul_out_vld = 1'b1;
    exp_upd.push_back(k);
    tick();
    mul_out_vld = 1'b0;
    chk_eq("upd_cycle", int'(upd_start), 1);
    chk_eq("opcnt_hold", int'(mul_op_cnt), k);
    stall_upd += 1 + UPD_LAT;
    repeat (UPD_LAT) tick();
    upd_done = 1'b1;
    if (last) exp_status.push_back(0);
    tick();
    upd_done = 1'b0;
  endtask

  // Issue the current pivot and stop at the falling edge of its ISSUE cycle.
  task automatic issue_only(input int k);
    wait_sig(0, 60, "wait_norm");
    tick();
    tick();
    norm_vld = 1'b1;
    exp_op.push_back(k);
    tick();
    norm_vld = 1'b0;
    chk_eq("issue_cycle", int'(mul_input_ready), 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (norm_rdy) norm_cnt++;
      if (mul_input_ready) begin
        if (exp_op.size() == 0) chk_eq("issue_unexpected", 1, 0);
        else chk_eq("issue_op_cnt", int'(mul_op_cnt), exp_op.pop_front());
      end
      if (upd_start) begin
        if (exp_upd.size() == 0) chk_eq("upd_unexpected", 1, 0);
        else chk_eq("upd_op_cnt", int'(upd_op_cnt), exp_upd.pop_front());
      end
      if (done) begin
        if (exp_status.size() == 0) chk_eq("done_unexpected", 1, 0);
        else chk_eq("done_status", int'(status), exp_status.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=hang want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    norm_vld = 1'b0;
    pivot_zero = 1'b0;
    mul_out_vld = 1'b0;
    upd_done = 1'b0;
    repeat (3) tick();
    chk_quiet("rst");
    reset = 1'b0;
    tick();
    chk_quiet("post_rst");

    // Nominal run with start-while-busy and a stray multiplier result on pivot 1.
    start_run();
    for (int k = 0; k < MS; k++) run_pivot(k, 8, k == MS - 1, k == 1);
    wait_sig(3, 30, "nom_done");
    tick();
    chk_eq("nom_busy_after", int'(busy), 0);
    chk_eq("nom_status_hold", int'(status), 0);
`ifdef GJ_SEQ_PERF_EN
    chk_eq("perf_cycles", int'(perf_cycles), busy_cnt);
    chk_eq("perf_stall", int'(perf_stall), norm_cnt + stall_upd);
`endif

    // Singular pivot at k=2.
    tick();
    start_run();
    run_pivot(0, 8, 1'b0, 1'b0);
    run_pivot(1, 8, 1'b0, 1'b0);
    wait_sig(0, 60, "sing_norm");
    tick();
    tick();
    norm_vld = 1'b1;
    pivot_zero = 1'b1;
    exp_status.push_back(1);
    tick();
    norm_vld = 1'b0;
    pivot_zero = 1'b0;
    chk_eq("sing_done", int'(done), 1);
    tick();
    chk_eq("sing_busy_after", int'(busy), 0);
    chk_eq("sing_status_hold", int'(status), 1);

    // Multiplier never answers.
    tick();
    start_run();
    issue_only(0);
    exp_status.push_back(2);
    repeat (MT) tick();
    chk_eq("to_not_yet", int'(done), 0);
    tick();
    chk_eq("to_done", int'(done), 1);
    tick();
    chk_eq("to_busy_after", int'(busy), 0);

    // Abort while the multiply is in flight, then a clean restart.
    tick();
    start_run();
    issue_only(0);
    repeat (3) tick();
    abort = 1'b1;
    exp_status.push_back(3);
    tick();
    abort = 1'b0;
    repeat (4) tick();
    mul_out_vld = 1'b1;
    tick();
    mul_out_vld = 1'b0;
    chk_eq("ab_done", int'(done), 1);
    tick();
    chk_eq("ab_busy_after", int'(busy), 0);
    start_run();
    // Pivot 1 answers on the very cycle the watchdog expires, which still counts.
    for (int k = 0; k < MS; k++) run_pivot(k, (k == 1) ? MT : 8, k == MS - 1, 1'b0);
    wait_sig(3, 30, "restart_done");
    tick();

    // Asynchronous reset in the middle of WAIT_UPD.
    start_run();
    run_pivot(0, 8, 1'b0, 1'b0);
    issue_only(1);
    repeat (8) tick();
    mul_out_vld = 1'b1;
    exp_upd.push_back(1);
    tick();
    mul_out_vld = 1'b0;
    chk_eq("pre_rst_upd_op_cnt", int'(upd_op_cnt), 1);
    chk_eq("pre_rst_mul_op_cnt", int'(mul_op_cnt), 1);
    #2 reset = 1'b1;
    #1 chk_quiet("async_rst");
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk_eq("rst_no_run_busy", int'(busy), 0);

    chk_eq("left_issue", exp_op.size(), 0);
    chk_eq("left_upd", exp_upd.size(), 0);
    chk_eq("left_done", exp_status.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
